// File: rtl/neander_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neander_pkg
// Description : Shared state encoding and RAM geometry for the Neander boot
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package neander_pkg;

    localparam int RAM_DEPTH = 256;

    typedef enum logic [2:0] {
        BOOT_CLEAR   = 3'd0,
        BOOT_LOAD    = 3'd1,
        BOOT_RELEASE = 3'd2,
        BOOT_RUN     = 3'd3
    } boot_state_t;

endpackage
`default_nettype wire

// File: rtl/neander_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neander_boot_sequencer
// Description : Holds the CPU in reset, zero-fills and loads RAM from a byte
//               stream, then hands the RAM port over to the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module neander_boot_sequencer
    import neander_pkg::*;
#(
    parameter int CLEAR_EN   = 1,
    parameter int LOAD_LEN   = 256,
    parameter int RESET_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       boot_skip,
    input  logic       load_req,
    input  logic       load_done,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    input  logic [7:0] cpu_mem_addr,
    input  logic [7:0] cpu_mem_data_out,
    input  logic       cpu_mem_write,
    input  logic       cpu_mem_read,
    output logic       cpu_reset,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_data_out,
    output logic       ram_write,
    output logic       ram_read,
    output logic [8:0] load_count,
    output logic [2:0] state_o
);

    localparam logic [8:0]  c_load_len  = 9'(LOAD_LEN);
    localparam logic [15:0] c_hold_last = 16'(RESET_HOLD - 1);
    localparam logic [7:0]  c_clr_last  = 8'(RAM_DEPTH - 1);
    localparam boot_state_t c_reset_state = (CLEAR_EN != 0) ? BOOT_CLEAR : BOOT_LOAD;

    boot_state_t state_q;
    logic        cpu_reset_q;
    logic        byte_ready_q;
    logic        wr_q;
    logic        done_q;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;
    logic [7:0]  clr_cnt_q;
    logic [7:0]  load_addr_q;
    logic [8:0]  count_q;
    logic [15:0] hold_q;

    logic        xfer_d;
    logic        terminate_d;
    logic        run_d;
    logic [8:0]  count_d;

    always_comb begin
        xfer_d  = (state_q == BOOT_LOAD) && !done_q && byte_valid && byte_ready_q;
        count_d = count_q;
        if (xfer_d && (count_q < c_load_len)) begin
            count_d = count_q + 9'd1;
        end
        terminate_d = load_done || (count_d == c_load_len);
        run_d       = (state_q == BOOT_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= c_reset_state;
            cpu_reset_q  <= 1'b1;
            byte_ready_q <= 1'b0;
            wr_q         <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= 8'd0;
            data_q       <= 8'd0;
            clr_cnt_q    <= 8'd0;
            load_addr_q  <= 8'd0;
            count_q      <= 9'd0;
            hold_q       <= 16'd0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                BOOT_CLEAR: begin
                    wr_q      <= 1'b1;
                    addr_q    <= clr_cnt_q;
                    data_q    <= 8'd0;
                    clr_cnt_q <= clr_cnt_q + 8'd1;
                    if (clr_cnt_q == c_clr_last) begin
                        if (boot_skip) begin
                            state_q <= BOOT_RELEASE;
                            hold_q  <= 16'd0;
                        end else begin
                            state_q      <= BOOT_LOAD;
                            count_q      <= 9'd0;
                            load_addr_q  <= 8'd0;
                            done_q       <= 1'b0;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                BOOT_LOAD: begin
                    if (done_q) begin
                        state_q <= BOOT_RELEASE;
                        hold_q  <= 16'd0;
                    end else begin
                        if (xfer_d) begin
                            wr_q        <= 1'b1;
                            addr_q      <= load_addr_q;
                            data_q      <= byte_data;
                            load_addr_q <= load_addr_q + 8'd1;
                            count_q     <= count_d;
                        end
                        // A byte taken in the ending cycle still needs one cycle to reach RAM.
                        if (terminate_d) begin
                            byte_ready_q <= 1'b0;
                            if (xfer_d) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= BOOT_RELEASE;
                                hold_q  <= 16'd0;
                            end
                        end else begin
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                BOOT_RELEASE: begin
                    cpu_reset_q <= 1'b1;
                    if (hold_q == c_hold_last) begin
                        state_q     <= BOOT_RUN;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 16'd1;
                    end
                end
                BOOT_RUN: begin
                    if (load_req) begin
                        state_q      <= BOOT_LOAD;
                        cpu_reset_q  <= 1'b1;
                        count_q      <= 9'd0;
                        load_addr_q  <= 8'd0;
                        done_q       <= 1'b0;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= c_reset_state;
                end
            endcase
        end
    end

    // The CPU owns the RAM port combinationally only while running.
    assign ram_addr     = run_d ? cpu_mem_addr     : addr_q;
    assign ram_data_out = run_d ? cpu_mem_data_out : data_q;
    assign ram_write    = run_d ? cpu_mem_write    : wr_q;
    assign ram_read     = run_d & cpu_mem_read;

    assign byte_ready = byte_ready_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_count = count_q;
    assign state_o    = state_q;

endmodule
`default_nettype wire
